// File: rtl/sram_boot_pkg.sv
// Shared types and default geometry for the SRAM boot sequencer and its SRAM bench.
package sram_boot_pkg;

    typedef enum logic [2:0] {IDLE, TRAIN, LOAD, BOOT, DONE} seq_state_t;

    localparam int unsigned SRAM_WIDTH = 8;
    localparam int unsigned SRAM_DEPTH = 16;
    localparam int unsigned SRAM_ADDR  = 16;

endpackage

// File: rtl/sram_rd_outreg.sv
// Single-entry output register for the boot stream: loads the 1-cycle SRAM read
// return and holds it until the consumer accepts it.
module sram_rd_outreg
    import sram_boot_pkg::*;
#(
    parameter int unsigned WIDTH = SRAM_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/sram_boot_sequencer.sv
// Sole driver of the SRAM port set: trains the macro, loads DEPTH words from an
// input stream, then streams them back out in address order.
module sram_boot_sequencer
    import sram_boot_pkg::*;
#(
    parameter int unsigned WIDTH        = SRAM_WIDTH,
    parameter int unsigned DEPTH        = SRAM_DEPTH,
    parameter int unsigned ADDR         = SRAM_ADDR,
    parameter int unsigned TRAIN_CYCLES = 40
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             s_valid_i,
    input  logic [WIDTH-1:0] s_data_i,
    output logic             s_ready_o,
    output logic             m_valid_o,
    output logic [WIDTH-1:0] m_data_o,
    input  logic             m_ready_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             sram_wren_o,
    output logic             sram_rden_o,
    output logic             sram_boot_o,
    output logic             sram_train_o,
    output logic [WIDTH-1:0] sram_din_o,
    output logic [ADDR-1:0]  sram_addr_o,
    input  logic [WIDTH-1:0] sram_dout_i
);

    localparam int unsigned   CW    = $clog2(DEPTH) + 1;
    localparam int unsigned   TW    = $clog2(TRAIN_CYCLES) + 1;
    localparam logic [CW-1:0] LAST  = CW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL  = CW'(DEPTH);
    localparam logic [TW-1:0] TLAST = TW'(TRAIN_CYCLES - 1);

    seq_state_t       state_q;
    logic [TW-1:0]    train_cnt_q;
    logic [CW-1:0]    wr_cnt_q;
    logic [CW-1:0]    rd_cnt_q;
    logic [CW-1:0]    ack_cnt_q;
    logic             ret_q;
    logic             s_ready_q;
    logic             busy_q;
    logic             done_q;
    logic             sram_wren_q;
    logic             sram_rden_q;
    logic             sram_boot_q;
    logic             sram_train_q;
    logic [WIDTH-1:0] sram_din_q;
    logic [ADDR-1:0]  sram_addr_q;

    logic             m_valid;
    logic             accept;
    logic             handshake;
    logic             rd_issue;

    assign accept    = s_valid_i && s_ready_q;
    assign handshake = m_valid && m_ready_i;
    // One read at a time: nothing in flight and the output slot free (or draining now).
    assign rd_issue  = (state_q == BOOT) && !sram_rden_q && !ret_q &&
                       (!m_valid || m_ready_i) && (rd_cnt_q < FULL);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            train_cnt_q  <= '0;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            ack_cnt_q    <= '0;
            ret_q        <= 1'b0;
            s_ready_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            sram_wren_q  <= 1'b0;
            sram_rden_q  <= 1'b0;
            sram_boot_q  <= 1'b0;
            sram_train_q <= 1'b0;
            sram_din_q   <= '0;
            sram_addr_q  <= '0;
        end else begin
            sram_wren_q <= 1'b0;
            sram_rden_q <= 1'b0;
            ret_q       <= sram_rden_q;
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        state_q      <= TRAIN;
                        train_cnt_q  <= '0;
                        wr_cnt_q     <= '0;
                        rd_cnt_q     <= '0;
                        ack_cnt_q    <= '0;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        sram_train_q <= 1'b1;
                        sram_boot_q  <= 1'b0;
                    end
                end
                TRAIN: begin
                    train_cnt_q <= train_cnt_q + 1'b1;
                    if (train_cnt_q == TLAST) begin
                        state_q      <= LOAD;
                        sram_train_q <= 1'b0;
                        s_ready_q    <= 1'b1;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        sram_wren_q <= 1'b1;
                        sram_din_q  <= s_data_i;
                        sram_addr_q <= ADDR'(wr_cnt_q);
                        wr_cnt_q    <= wr_cnt_q + 1'b1;
                        if (wr_cnt_q == LAST) begin
                            s_ready_q   <= 1'b0;
                            state_q     <= BOOT;
                            sram_boot_q <= 1'b1;
                        end
                    end
                end
                BOOT: begin
                    if (rd_issue) begin
                        sram_rden_q <= 1'b1;
                        sram_addr_q <= ADDR'(rd_cnt_q);
                        rd_cnt_q    <= rd_cnt_q + 1'b1;
                    end
                    if (handshake) begin
                        ack_cnt_q <= ack_cnt_q + 1'b1;
                        if (ack_cnt_q == LAST) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    sram_rd_outreg #(
        .WIDTH(WIDTH)
    ) u_outreg (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (ret_q),
        .data_i (sram_dout_i),
        .ready_i(m_ready_i),
        .valid_o(m_valid),
        .data_o (m_data_o)
    );

    assign m_valid_o    = m_valid;
    assign s_ready_o    = s_ready_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign sram_wren_o  = sram_wren_q;
    assign sram_rden_o  = sram_rden_q;
    assign sram_boot_o  = sram_boot_q;
    assign sram_train_o = sram_train_q;
    assign sram_din_o   = sram_din_q;
    assign sram_addr_o  = sram_addr_q;

endmodule

// File: tb/tb_sram_boot_sequencer.sv
// Randomized bench for sram_boot_sequencer with a behavioural SRAM and stream model.
module tb_sram_boot_sequencer;
    import sram_boot_pkg::*;

    localparam int W  = SRAM_WIDTH;
    localparam int D  = SRAM_DEPTH;
    localparam int A  = SRAM_ADDR;
    localparam int TC = 40;
    localparam int AW = $clog2(D);

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start, s_valid, s_ready, m_valid, m_ready;
    logic [W-1:0] s_data, m_data, sram_din, sram_dout;
    logic         busy, done, sram_wren, sram_rden, sram_boot, sram_train;
    logic [A-1:0] sram_addr;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    sram_boot_sequencer #(
        .WIDTH(W), .DEPTH(D), .ADDR(A), .TRAIN_CYCLES(TC)
    ) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .s_valid_i(s_valid), .s_data_i(s_data), .s_ready_o(s_ready),
        .m_valid_o(m_valid), .m_data_o(m_data), .m_ready_i(m_ready),
        .busy_o(busy), .done_o(done),
        .sram_wren_o(sram_wren), .sram_rden_o(sram_rden),
        .sram_boot_o(sram_boot), .sram_train_o(sram_train),
        .sram_din_o(sram_din), .sram_addr_o(sram_addr), .sram_dout_i(sram_dout)
    );

    // Behavioural SRAM: write on wren, data_out valid the cycle after rden.
    logic [W-1:0] mem [D];
    logic [A-1:0] wr_addr_log [$];
    logic [W-1:0] wr_data_log [$];
    int           rd_issued = 0;

    always @(posedge clk) begin
        if (sram_wren) begin
            mem[sram_addr[AW-1:0]] <= sram_din;
            wr_addr_log.push_back(sram_addr);
            wr_data_log.push_back(sram_din);
        end
        if (sram_rden) begin
            sram_dout <= mem[sram_addr[AW-1:0]];
            rd_issued++;
        end
    end

    logic [W-1:0] exp_w [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [63:0] outs();
        return 64'({s_ready, m_valid, m_data, busy, done, sram_wren, sram_rden,
                    sram_boot, sram_train, sram_din, sram_addr});
    endfunction

    task automatic chk_excl();
        chk("wren_rden_excl", 64'(sram_wren & sram_rden), 64'd0);
        chk("train_boot_excl", 64'(sram_train & sram_boot), 64'd0);
    endtask

    task automatic run_train();
        int   n   = 0;
        logic bad = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_train", 64'(busy), 64'd1);
        chk("done_cleared", 64'(done), 64'd0);
        while (sram_train && n < 200) begin
            n++;
            if (sram_wren || sram_rden || s_ready || sram_boot) bad = 1'b1;
            @(negedge clk);
        end
        chk("train_len", 64'(n), 64'(TC));
        chk("train_quiet", 64'(bad), 64'd0);
        chk("sready_after_train", 64'(s_ready), 64'd1);
    endtask

    // mode 0: s_valid held high with data 1..D; 1: toggling; 2: random
    task automatic run_load(input int mode, input int stop_after);
        int   acc = 0;
        int   cyc = 0;
        logic sv;
        while (acc < D && cyc < 400) begin
            sv = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            if (mode == 0) chk("sready_load", 64'(s_ready), 64'd1);
            chk("sram_boot_load", 64'(sram_boot), 64'd0);
            chk_excl();
            s_valid = sv;
            s_data  = (mode == 0) ? W'(acc + 1) : W'($urandom);
            if (sv && s_ready) begin
                exp_w.push_back(s_data);
                acc++;
            end
            @(negedge clk);
            cyc++;
            if (stop_after != 0 && acc == stop_after) return;
        end
        if (acc < D) chk("load_timeout", 64'(acc), 64'(D));
        else begin
            chk("sready_drop", 64'(s_ready), 64'd0);
            s_valid = 1'b1;
            s_data  = 8'h11;
        end
    endtask

    // mode 0: m_ready always 1; 1: random m_ready; 2: hold m_ready low 10 cycles on word 4
    task automatic run_boot(input int mode);
        int           k = 0, cyc = 0, last = 0, r0;
        logic         mr;
        logic         bp_done = 1'b0;
        logic [W-1:0] held;
        while (k < D && cyc < 2000) begin
            if (mode == 2 && k == 4 && m_valid && !bp_done) begin
                bp_done = 1'b1;
                m_ready = 1'b0;
                held    = m_data;
                r0      = rd_issued;
                repeat (10) begin
                    @(negedge clk);
                    cyc++;
                    chk("bp_valid", 64'(m_valid), 64'd1);
                    chk("bp_data", 64'(m_data), 64'(held));
                end
                chk("bp_no_rden", 64'(rd_issued - r0), 64'd0);
                chk("bp_word", 64'(held), 64'(exp_w[4]));
            end
            mr      = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            m_ready = mr;
            chk_excl();
            if (m_valid && mr) begin
                chk("m_data", 64'(m_data), 64'(exp_w[k]));
                chk("boot_high", 64'(sram_boot), 64'd1);
                if (mode == 0 && k > 0) chk("hs_gap", 64'(cyc - last), 64'd3);
                last = cyc;
                k++;
            end
            @(negedge clk);
            cyc++;
        end
        if (k < D) chk("boot_timeout", 64'(k), 64'(D));
    endtask

    task automatic full_run(input int lmode, input int bmode);
        int wbase, rbase;
        m_ready = (bmode == 0);
        run_train();
        exp_w.delete();
        wbase = wr_addr_log.size();
        rbase = rd_issued;
        run_load(lmode, 0);
        run_boot(bmode);
        chk("done", 64'(done), 64'd1);
        chk("busy_in_done", 64'(busy), 64'd0);
        chk("boot_held", 64'(sram_boot), 64'd1);
        chk("mvalid_done", 64'(m_valid), 64'd0);
        chk("enables_done", 64'({sram_wren, sram_rden, sram_train}), 64'd0);
        chk("wr_count", 64'(wr_addr_log.size() - wbase), 64'(D));
        chk("rd_count", 64'(rd_issued - rbase), 64'(D));
        for (int i = 0; i < D; i++) begin
            if (wbase + i < wr_addr_log.size()) begin
                chk("wr_addr", 64'(wr_addr_log[wbase + i]), 64'(i));
                chk("wr_data", 64'(wr_data_log[wbase + i]), 64'(exp_w[i]));
            end
        end
        s_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        start = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        #1 rst = 1'b1;
        #11 chk("reset_outputs", outs(), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_outputs", outs(), 64'd0);

        // Reset mid-LOAD after 5 accepted words.
        run_train();
        exp_w.delete();
        run_load(0, 5);
        #2 rst = 1'b1;
        #1 chk("reset_async", outs(), 64'd0);
        @(negedge clk);
        chk("reset_held", outs(), 64'd0);
        s_valid = 1'b0;
        rst     = 1'b0;
        @(negedge clk);

        full_run(0, 0);
        full_run(1, 2);
        full_run(2, 1);
        full_run(2, 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
